inv_shl_search: RTL
===================

Name: inv_shl_search

Overview:
- Sequential invertibility solver for shift-left constraints, WIDTH bits wide.
- Given operand s, target t, comparison op and shift position, it finds x that satisfies (x << s) op t (pos=0) or (s << x) op t (pos=1).
- Replaces fixed 4-bit combinational Skolem functions with a parametrised width and selectable comparison modes. Inverse queries use a valid/ready handshake in the solver back-end.

Parameters:
- WIDTH, 8, bit width of s, t, x; legal range 2..16.
- CNT_W, WIDTH+1, search counter width (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  query valid
- in_ready  output  1  high only in IDLE
- s  input  WIDTH  fixed operand
- t  input  WIDTH  target value
- op  input  2  comparison: 00 sge, 01 sgt, 10 uge, 11 ugt
- pos  input  1  0: x is the shifted value (x<<s); 1: x is the shift amount (s<<x)
- flush  input  1  abort any query, return to IDLE
- out_valid  output  1  result valid
- out_ready  input  1  result accepted
- found  output  1  1 if a satisfying x exists
- x  output  WIDTH  solution; 0 when found=0

Behaviour:
- Shift semantics: the shift amount is the full WIDTH-bit unsigned value; amount >= WIDTH yields 0. Signed compares use two's complement.
- Reset: state=IDLE, in_ready=1, out_valid=0, found=0, x=0, counter=0, query registers=0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_valid && in_ready (cycle C) latches s, t, op, pos; clears counter k to 0; goes to SEARCH.
- SEARCH:
  - One candidate per cycle. Candidate k is evaluated in cycle C+1+k, in ascending unsigned order.
  - First hit: x=k, found=1, go to DONE. out_valid rises at C+2+k.
  - k = 2^WIDTH-1 with no hit: found=0, x=0, go to DONE. out_valid rises at C+1+2^WIDTH.
  - Without the optional feature, the result is the smallest satisfying x.
- DONE:
  - out_valid=1; found and x stay stable while out_ready=0.
  - out_valid && out_ready: go to IDLE. in_ready is 1 in the next cycle; there is no same-cycle re-accept.
- flush:
  - Highest priority in any state: next state IDLE, out_valid=0, found and x cleared.
  - An in_valid in the same cycle as flush is ignored.
- Reset mid-search: immediate return to reset values. No partial result is emitted.
- Inputs s, t, op, pos are ignored outside the accept cycle.

Optional Feature:
- Macro: INV_SHL_FAST_PATH_EN.
- With the macro, pos=0 queries evaluate one closed-form candidate in cycle C+1:
  - s < WIDTH: x = SMAX>>s for signed ops, all-ones>>s for unsigned ops.
  - s >= WIDTH: x = 0.
- This candidate produces the maximum reachable x<<s, so its check decides invertibility exactly.
- Fast-path result: out_valid at C+2, found = check result, x = candidate if found else 0. The solution need not be the smallest.
- pos=1 queries always use the exhaustive search.
- Without the macro, all queries use the exhaustive search.

Decomposition:
- Package inv_shl_pkg holds:
  - op_e enum (OP_SGE, OP_SGT, OP_UGE, OP_UGT).
  - state_e enum (IDLE, SEARCH, DONE).
  - Helper functions shl_sat(val, amt) and cmp_op(a, b, op).
- One combinational sub-module, inv_shl_check: inputs x, s, t, op, pos; output sat. It is shared by the search path and the fast path.

Test Plan (WIDTH=4):
- pos=0, op=sge, s=1, t=4'b0110 -> found=1, x=3.
  - Without macro: out_valid at C+5.
  - With macro: out_valid at C+2, x=3.
- pos=0, op=sgt, s=1, t=4'b0110 (max reachable 6, not > 6) -> found=0, x=0.
  - Without macro: out_valid at C+17.
  - With macro: out_valid at C+2.
- pos=1, op=uge, s=4'b0011, t=4'b1100 -> found=1, x=2 (3<<2=12), out_valid at C+4, both builds.
- pos=0, op=sge, s=4, t=4'b1000 (shift >= WIDTH gives 0, 0 >= -8) -> found=1, x=0, out_valid at C+2.
- Hold out_ready=0 for 5 cycles after out_valid -> out_valid, found, x stable and in_ready=0. Then pulse out_ready -> in_ready=1 the following cycle.
- Flush at C+3 during the sgt search -> IDLE next cycle, out_valid never asserts. A new query then completes correctly.
- Deassert rst_n mid-search -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/inv_shl_pkg.sv
// Shared types and helpers for the shift-left invertibility solver.
// Optional build macro used by the solver: INV_SHL_FAST_PATH_EN.
package inv_shl_pkg;

  // Widest legal WIDTH; the helpers work on values zero-padded to this size.
  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    OP_SGE = 2'b00,
    OP_SGT = 2'b01,
    OP_UGE = 2'b10,
    OP_UGT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  // Shift left within a w-bit word; any amount >= w yields zero.
  function automatic logic [MAX_W-1:0] shl_sat(input logic [MAX_W-1:0] val,
                                              input logic [MAX_W-1:0] amt,
                                              input int w);
    logic [MAX_W:0]   mask_full;
    logic [MAX_W-1:0] res;
    mask_full = (17'd1 << w) - 17'd1;
    if (amt >= MAX_W'(w)) res = '0;
    else                  res = (val << amt) & mask_full[MAX_W-1:0];
    return res;
  endfunction

  // Compare two w-bit values. Both are left-aligned to MAX_W bits first so the
  // w-bit sign bit lands in the MSB and a plain MAX_W-bit compare is exact.
  function automatic logic cmp_op(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input op_e              op,
                                  input int               w);
    logic [MAX_W-1:0] a_al;
    logic [MAX_W-1:0] b_al;
    logic             res;
    a_al = a << (MAX_W - w);
    b_al = b << (MAX_W - w);
    case (op)
      OP_SGE:  res = $signed(a_al) >= $signed(b_al);
      OP_SGT:  res = $signed(a_al) >  $signed(b_al);
      OP_UGE:  res = a_al >= b_al;
      default: res = a_al >  b_al;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inv_shl_check.sv
// Combinational constraint check: sat = (x << s) op t when pos=0,
// sat = (s << x) op t when pos=1. Shared by the search and fast paths.
module inv_shl_check
  import inv_shl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  input  op_e              op,
  input  logic             pos,
  output logic             sat
);

  logic [MAX_W-1:0] val;
  logic [MAX_W-1:0] amt;

  // Pick which operand is shifted and which is the amount, then compare.
  always_comb begin
    val = pos ? MAX_W'(s) : MAX_W'(x);
    amt = pos ? MAX_W'(x) : MAX_W'(s);
    sat = cmp_op(shl_sat(val, amt, WIDTH), MAX_W'(t), op, WIDTH);
  end

endmodule

// File: rtl/inv_shl_search.sv
// Sequential invertibility solver for shift-left constraints.
// Searches x in ascending order, one candidate per cycle, and returns the
// first x with (x<<s) op t (pos=0) or (s<<x) op t (pos=1).
// Build macro INV_SHL_FAST_PATH_EN: pos=0 queries check a single closed-form
// candidate (the largest reachable x<<s) instead of searching.
module inv_shl_search
  import inv_shl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  input  logic [1:0]       op,
  input  logic             pos,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic [WIDTH-1:0] x
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] s_q, t_q;
  op_e              op_q;
  logic             pos_q;
  logic             load;

  logic [WIDTH-1:0] cand;
  logic             sat;
  logic             fast_path;
  logic             last_k;

  assign last_k = (k_q == CNT_W'((1 << WIDTH) - 1));

`ifdef INV_SHL_FAST_PATH_EN
  logic [WIDTH-1:0] fast_x;

  // Closed-form candidate: the x whose shift reaches the largest value allowed
  // by the signedness of the compare; shifts past the width leave x = 0.
  always_comb begin
    if (op_q == OP_SGE || op_q == OP_SGT) fast_x = {1'b0, {(WIDTH-1){1'b1}}} >> s_q;
    else                                  fast_x = {WIDTH{1'b1}} >> s_q;
    fast_path = ~pos_q;
    cand      = fast_path ? fast_x : k_q[WIDTH-1:0];
  end
`else
  // Only the exhaustive search exists: the candidate is the counter.
  always_comb begin
    fast_path = 1'b0;
    cand      = k_q[WIDTH-1:0];
  end
`endif

  inv_shl_check #(.WIDTH(WIDTH)) u_check (
    .x   (cand),
    .s   (s_q),
    .t   (t_q),
    .op  (op_q),
    .pos (pos_q),
    .sat (sat)
  );

  // Next-state and result logic; flush overrides every state.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    found_d = found_q;
    x_d     = x_q;
    load    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      found_d = 1'b0;
      x_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            k_d     = '0;
            found_d = 1'b0;
            x_d     = '0;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (sat) begin
            found_d = 1'b1;
            x_d     = cand;
            state_d = DONE;
          end else if (fast_path || last_k) begin
            found_d = 1'b0;
            x_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            found_d = 1'b0;
            x_d     = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      found_q <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      found_q <= found_d;
      x_q     <= x_d;
    end
  end

  // Query registers, captured only in the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      t_q   <= '0;
      op_q  <= OP_SGE;
      pos_q <= 1'b0;
    end else if (load) begin
      s_q   <= s;
      t_q   <= t;
      op_q  <= op_e'(op);
      pos_q <= pos;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign found     = found_q;
  assign x         = x_q;

endmodule
